lcd_bus_arbiter: RTL
====================

Name: lcd_bus_arbiter

Overview:
Owns the shared HD44780 character-LCD bus and interleaves writes from two client blocks, e.g. a status-line writer and a message writer.
- After reset it waits out LCD power-up and runs the fixed init sequence itself.
- It then grants bus writes round-robin between requesters 0 and 1.
- For every write it generates RS/DATA setup, the E strobe and the post-write wait.
- Sits between client text generators and the board LCD pins.

Parameters:
POWERUP_CYC, 750000, cycles with E low after reset before the first init write (15 ms at 50 MHz)
SETUP_CYC, 2, cycles RS/DATA are stable with E low before E rises (min 1)
E_HIGH_CYC, 25, cycles E is held high (min 1)
CMD_WAIT_CYC, 2000, cycles after E falls for a normal write (40 us)
CLEAR_WAIT_CYC, 82000, cycles after E falls for command 0x01 or 0x02 with RS=0 (1.64 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a byte
req0_rs  in  1  0 = command, 1 = character data
req0_data  in  8  byte to write
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid, req1_rs, req1_data, req1_ready  same as requester 0
init_done  out  1  init sequence complete; stays high until reset
busy  out  1  a write is in progress (state != IDLE)
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  constant 0
lcd_on  out  1  constant 1
lcd_blon  out  1  constant 1
lcd_data  out  8  LCD data bus

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state POWERUP, lcd_e=0, lcd_rs=0, lcd_data=0, init_done=0, busy=1, both ready=0, last_grant=1 (so requester 0 wins the first tie).
- All LCD outputs are registered. lcd_rw/lcd_on/lcd_blon are constant and unaffected by reset.
- States: POWERUP -> INIT_LOAD -> SETUP -> EHIGH -> WAIT -> (INIT_LOAD | IDLE); IDLE -> SETUP on accept.
- POWERUP:
  - Counts POWERUP_CYC cycles, then goes to INIT_LOAD.
  - The first cycle after rst deasserts is POWERUP cycle 0.
- INIT_LOAD (1 cycle):
  - Loads init ROM entry k: 0x38, 0x0C, 0x06, 0x01, always with RS=0.
  - Goes to SETUP.
- SETUP (SETUP_CYC cycles): lcd_rs and lcd_data driven from the latched byte, lcd_e=0.
- EHIGH (E_HIGH_CYC cycles): lcd_e=1; lcd_rs and lcd_data unchanged.
- WAIT:
  - lcd_e=0; lcd_rs and lcd_data are held until the next write loads.
  - Lasts CLEAR_WAIT_CYC if the latched RS=0 and the byte is 0x01 or 0x02, else CMD_WAIT_CYC.
  - On exit: if init is in progress and k<3, increment k and go to INIT_LOAD. If k=3, set init_done and go to IDLE.
- IDLE and acceptance:
  - reqN_ready is combinational and only asserted in IDLE with init_done=1.
  - Only one requester is ready at a time.
  - If exactly one is valid, it gets ready. If both are valid, the requester that is not last_grant gets ready.
  - An accept is ready&&valid. On accept: latch rs/data, update last_grant, go to SETUP next cycle.
  - Requesters hold valid, rs and data stable until accepted. The block never drops a latched byte.
- Spacing: accept-to-accept is 1+SETUP_CYC+E_HIGH_CYC+wait cycles. Each init write also takes 1 (load)+SETUP+EHIGH+wait.
- Counter: a single down-counter of width $clog2(max parameter + 1), reloaded at each state entry.
- Reset mid-operation: the next edge forces lcd_e=0, clears init_done and restarts POWERUP. A partial write is abandoned and the full init is repeated.
- Valid held with no accept (during init or busy): no effect, no loss.

Decomposition:
- Package lcd_pkg:
  - state enum;
  - HD44780 command constants: CMD_FUNC_8B_2L=8'h38, CMD_DISP_ON=8'h0C, CMD_ENTRY_INC=8'h06, CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_LINE1=8'h80, CMD_LINE2=8'hC0;
  - init ROM as a 4-entry constant array.
- One sub-module, lcd_strobe_seq: given a start pulse plus rs/data, runs SETUP/EHIGH/WAIT, selects the long wait itself and returns done. The top level contains only the arbiter, the init sequencer and the POWERUP counter.

Test Plan:
Bench parameters for all scenarios: POWERUP_CYC=20, SETUP_CYC=2, E_HIGH_CYC=3, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=40. Under these, a normal write is 16 cycles and a clear is 46.
1. Reset release, no requests -> lcd_data shows 0x38, 0x0C, 0x06, 0x01 in order with RS=0. E rises at cycles 23, 39, 55, 71, each pulse 3 cycles long. init_done=1 at cycle 114. No ready during init.
2. After init, req0 writes RS=1 data 0x54 -> ready for 1 cycle. E high 3 cycles starting 3 cycles after accept, with lcd_rs=1 and lcd_data=0x54. Next ready no earlier than 16 cycles after accept.
3. Both requesters continuously valid (req0 0x41, req1 0x42) -> grants alternate 0,1,0,1 starting with 0. Accepts are exactly 16 cycles apart.
4. req1 sends RS=0 0x01 and then RS=0 0xC0 -> accepts are 46 cycles apart. The same 0x01 with RS=1 gives 16-cycle spacing.
5. Assert rst while E is high during a user write -> lcd_e=0 the next cycle, init_done=0. The full init repeats with timing identical to scenario 1.
6. req0 valid during init with data 0x33 -> held with no ready until init_done. Accepted on the first IDLE cycle, exactly once, and 0x33 appears on lcd_data.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encodings, HD44780 command bytes and init ROM for the LCD bus arbiter.
package lcd_pkg;
  typedef enum logic [1:0] {AR_POWERUP, AR_INIT_LOAD, AR_WRITE, AR_IDLE} arb_state_t;
  typedef enum logic [1:0] {SQ_IDLE, SQ_SETUP, SQ_EHIGH, SQ_WAIT} seq_state_t;
  localparam logic [7:0] CMD_FUNC_8B_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_LINE1      = 8'h80;
  localparam logic [7:0] CMD_LINE2      = 8'hC0;
  // entry 0 sits in the low byte
  localparam logic [3:0][7:0] INIT_ROM = {CMD_CLEAR, CMD_ENTRY_INC, CMD_DISP_ON, CMD_FUNC_8B_2L};
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_strobe_seq.sv
// lcd_strobe_seq: drives one HD44780 write (setup, E strobe, post-write wait) and flags done.
module lcd_strobe_seq
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);
  localparam int CW = $clog2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC)) + 1);
  seq_state_t state;
  logic [CW-1:0] cnt;
  logic long_wait;
  // clear and home need the long busy time
  assign long_wait = !lcd_rs && (lcd_data == CMD_CLEAR || lcd_data == CMD_HOME);
  assign done = state == SQ_WAIT && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SQ_IDLE;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      case (state)
        SQ_IDLE: if (start) begin
          state    <= SQ_SETUP;
          cnt      <= CW'(SETUP_CYC - 1);
          lcd_rs   <= rs;
          lcd_data <= data;
        end
        SQ_SETUP: if (cnt == '0) begin
          state <= SQ_EHIGH;
          cnt   <= CW'(E_HIGH_CYC - 1);
          lcd_e <= 1'b1;
        end else cnt <= cnt - 1'b1;
        SQ_EHIGH: if (cnt == '0) begin
          state <= SQ_WAIT;
          cnt   <= long_wait ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
          lcd_e <= 1'b0;
        end else cnt <= cnt - 1'b1;
        SQ_WAIT: if (cnt == '0) state <= SQ_IDLE;
          else cnt <= cnt - 1'b1;
        default: state <= SQ_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns the HD44780 bus, runs power-up init, then round-robins writes from two clients.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic [7:0] lcd_data
);
  localparam int PW = $clog2(POWERUP_CYC + 1);
  arb_state_t state;
  logic [PW-1:0] pcnt;
  logic [1:0] k;
  logic last_grant, grant_ok, accept, start, seq_done, sel_rs;
  logic [7:0] sel_data;
  assign grant_ok   = state == AR_IDLE && init_done;
  // on a tie the requester that did not win last time is served
  assign req0_ready = grant_ok && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = grant_ok && req1_valid && (!req0_valid || !last_grant);
  assign accept     = req0_ready || req1_ready;
  assign start      = state == AR_INIT_LOAD || accept;
  assign sel_rs     = state == AR_INIT_LOAD ? 1'b0 : req1_ready ? req1_rs : req0_rs;
  assign sel_data   = state == AR_INIT_LOAD ? INIT_ROM[k] : req1_ready ? req1_data : req0_data;
  assign busy       = state != AR_IDLE;
  assign lcd_rw     = 1'b0;
  assign lcd_on     = 1'b1;
  assign lcd_blon   = 1'b1;
  lcd_strobe_seq #(
    .SETUP_CYC     (SETUP_CYC),
    .E_HIGH_CYC    (E_HIGH_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rs      (sel_rs),
    .data    (sel_data),
    .done    (seq_done),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AR_POWERUP;
      pcnt       <= PW'(POWERUP_CYC - 1);
      k          <= '0;
      init_done  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        AR_POWERUP: if (pcnt == '0) state <= AR_INIT_LOAD;
          else pcnt <= pcnt - 1'b1;
        AR_INIT_LOAD: state <= AR_WRITE;
        AR_WRITE: if (seq_done) begin
          if (init_done) state <= AR_IDLE;
          else if (k == 2'd3) begin
            init_done <= 1'b1;
            state     <= AR_IDLE;
          end else begin
            k     <= k + 1'b1;
            state <= AR_INIT_LOAD;
          end
        end
        AR_IDLE: if (accept) begin
          state      <= AR_WRITE;
          last_grant <= req1_ready;
        end
        default: state <= AR_POWERUP;
      endcase
    end
  end
endmodule
